wb_sram_arbiter: RTL and testbench
==================================

Name: wb_sram_arbiter

Overview:
Round-robin Wishbone arbiter that shares the single SPI SRAM slave port between two masters: the UART bridge (m0) and the levenshtein controller (m1).
- Sits between the interconnect's SRAM-side paths and spi_controller.
- Grants whole bus cycles (cyc-framed).
- Includes an optional stalled-transfer watchdog.

Parameters:
ADDR_WIDTH, 23, width of all address ports.
TIMEOUT_CYCLES, 1023, watchdog limit in clocks; legal range 2..65535.

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous active-high reset
wbm0_cyc_i / wbm1_cyc_i  in  1  master cycle request
wbm0_stb_i / wbm1_stb_i  in  1  master strobe
wbm0_we_i / wbm1_we_i  in  1  write enable
wbm0_adr_i / wbm1_adr_i  in  ADDR_WIDTH  address
wbm0_dat_i / wbm1_dat_i  in  8  write data
wbm0_ack_o / wbm1_ack_o  out  1  acknowledge
wbm0_err_o / wbm1_err_o  out  1  error
wbm0_rty_o / wbm1_rty_o  out  1  retry
wbm0_dat_o / wbm1_dat_o  out  8  read data
wbs_cyc_o, wbs_stb_o, wbs_we_o  out  1 each  to SRAM slave
wbs_adr_o  out  ADDR_WIDTH  to SRAM slave
wbs_dat_o  out  8  to SRAM slave
wbs_ack_i, wbs_err_i, wbs_rty_i  in  1 each  from SRAM slave
wbs_dat_i  in  8  from SRAM slave
grant_o  out  2  one-hot current owner (bit0=m0, bit1=m1), 00 when idle

Behaviour:
- Clocking: one clock domain, clk_i. Reset is synchronous and active-high on rst_i.
- State: IDLE, OWN0, OWN1.
- Priority pointer `last` (1 bit) records the most recent owner.
- Reset state: IDLE, last=1 (so m0 wins the first tie), watchdog count 0.
- Outputs while in reset and in IDLE:
  - all master ack/err/rty = 0.
  - wbs_cyc/stb/we = 0; wbs_adr/dat = 0.
  - grant_o = 00.
- IDLE: grants on cyc_i alone.
  - Only one cyc_i high -> go to that OWNx next clock.
  - Both high -> grant the master != last.
- Grant latency: one clock. The request is sampled at edge N; the slave sees the master's signals from cycle N+1.
- OWNx (slave path is combinational while owning):
  - wbs_cyc/stb/we/adr/dat = wbmx_*.
  - wbmx_ack/err/rty = wbs_*; wbmx_dat_o = wbs_dat_i.
  - last := x on entry.
  - Grant is held for as long as wbmx_cyc_i stays high; multi-transfer cycles are not interrupted.
- Non-owner: ack/err/rty forced 0; dat_o = wbs_dat_i (don't care).
- Releasing a grant (owner drops cyc_i at edge N):
  - Other master's cyc_i high -> switch directly to OWN(other) at N+1, with no idle cycle.
  - Otherwise -> IDLE.
- Owner raises cyc_i again in the same cycle the other is granted: it waits. Strict alternation under contention.
- rst_i mid-transfer: next cycle IDLE, all outputs 0. The slave sees cyc drop, which aborts it. No ack is delivered afterwards.
- Slave err/rty are passed through only; the arbiter does not retry.

Optional Feature:
Macro WB_SRAM_ARB_WATCHDOG_EN.

Defined:
- A 16-bit counter increments each clock while in OWNx with wbs_stb_o=1 and none of ack/err/rty asserted.
- The counter clears on any ack/err/rty, on a state change, or on reset.
- When the count reaches TIMEOUT_CYCLES-1:
  - Assert wbmx_err_o for exactly one clock.
  - Force wbs_cyc_o/wbs_stb_o = 0 from that clock until the owner drops cyc_i; set sticky flag `aborted`.
  - Slave ack/err/rty are not forwarded while `aborted`.
  - `aborted` clears on leaving OWNx.
- Total: err arrives TIMEOUT_CYCLES clocks after the stalled stb becomes visible at the slave.

Undefined: no counter; a stalled slave holds the grant indefinitely.

Test Plan:
1. Reset, then m0 only: write adr=0x000010, dat=0xA5; slave acks 3 clks later -> wbs_cyc_o rises 1 clk after request, wbm0_ack_o pulses once, grant_o=01, wbm1_ack_o stays 0.
2. m0 and m1 raise cyc in the same cycle straight after reset -> m0 granted first; on m0 cyc drop, grant_o goes to 10 on the next clock with no IDLE cycle.
3. Both masters request continuously, 4 single-beat cycles each -> grants alternate 01,10,01,10…; neither master gets two consecutive grants.
4. m1 holds cyc across 3 stb/ack beats while m0 requests -> m0 waits; all 3 m1 beats complete before grant_o becomes 01.
5. rst_i asserted while OWN1 with stb pending -> next clock: wbs_cyc_o=0, grant_o=00, no ack on either master, even if the slave acks that clock.
6. WB_SRAM_ARB_WATCHDOG_EN, TIMEOUT_CYCLES=8, slave never acks -> wbm0_err_o high for 1 clk, 8 clks after wbs_stb_o rose; wbs_cyc_o low until m0 drops cyc; a later m1 request is granted normally.

Source files
------------

// File: rtl/wb_sram_arbiter_if.sv
// Wishbone bundle around wb_sram_arbiter: both master-side request/response paths
// plus the shared SRAM slave path.
// The slave modport is the arbiter's view, because the arbiter serves the masters.
// The master modport is the environment's view: the two masters plus the SRAM slave.
interface wb_sram_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 23
);
  logic                  wbm0_cyc_i, wbm0_stb_i, wbm0_we_i;
  logic [ADDR_WIDTH-1:0] wbm0_adr_i;
  logic [7:0]            wbm0_dat_i;
  logic                  wbm0_ack_o, wbm0_err_o, wbm0_rty_o;
  logic [7:0]            wbm0_dat_o;

  logic                  wbm1_cyc_i, wbm1_stb_i, wbm1_we_i;
  logic [ADDR_WIDTH-1:0] wbm1_adr_i;
  logic [7:0]            wbm1_dat_i;
  logic                  wbm1_ack_o, wbm1_err_o, wbm1_rty_o;
  logic [7:0]            wbm1_dat_o;

  logic                  wbs_cyc_o, wbs_stb_o, wbs_we_o;
  logic [ADDR_WIDTH-1:0] wbs_adr_o;
  logic [7:0]            wbs_dat_o;
  logic                  wbs_ack_i, wbs_err_i, wbs_rty_i;
  logic [7:0]            wbs_dat_i;

  modport slave (
    input  wbm0_cyc_i, wbm0_stb_i, wbm0_we_i, wbm0_adr_i, wbm0_dat_i,
    output wbm0_ack_o, wbm0_err_o, wbm0_rty_o, wbm0_dat_o,
    input  wbm1_cyc_i, wbm1_stb_i, wbm1_we_i, wbm1_adr_i, wbm1_dat_i,
    output wbm1_ack_o, wbm1_err_o, wbm1_rty_o, wbm1_dat_o,
    output wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_adr_o, wbs_dat_o,
    input  wbs_ack_i, wbs_err_i, wbs_rty_i, wbs_dat_i
  );

  modport master (
    output wbm0_cyc_i, wbm0_stb_i, wbm0_we_i, wbm0_adr_i, wbm0_dat_i,
    input  wbm0_ack_o, wbm0_err_o, wbm0_rty_o, wbm0_dat_o,
    output wbm1_cyc_i, wbm1_stb_i, wbm1_we_i, wbm1_adr_i, wbm1_dat_i,
    input  wbm1_ack_o, wbm1_err_o, wbm1_rty_o, wbm1_dat_o,
    input  wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_adr_o, wbs_dat_o,
    output wbs_ack_i, wbs_err_i, wbs_rty_i, wbs_dat_i
  );
endinterface

// File: rtl/wb_sram_arbiter.sv
// Round-robin Wishbone arbiter sharing one SPI SRAM slave between m0 (UART bridge)
// and m1 (levenshtein controller). Whole cyc-framed cycles are granted.
// Optional stalled-transfer watchdog: define WB_SRAM_ARB_WATCHDOG_EN.
module wb_sram_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 23,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic             clk_i,
  input  logic             rst_i,
  wb_sram_arbiter_if.slave bus,
  output logic [1:0]       grant_o
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be within 2..65535");
  end

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

  state_e                state_q, state_d;
  logic                  last_q, last_d;   // 1: m1 was the most recent owner
  logic [1:0]            grant_q, grant_d;
  logic [ADDR_WIDTH-1:0] adr_mux;
  logic                  aborted;          // watchdog has cut the slave off
  logic                  wd_err;           // one-clock timeout error to the owner

  // Pick the next owner from the cyc requests and the round-robin pointer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (bus.wbm0_cyc_i && bus.wbm1_cyc_i) state_d = last_q ? StOwn0 : StOwn1;
        else if (bus.wbm0_cyc_i)              state_d = StOwn0;
        else if (bus.wbm1_cyc_i)              state_d = StOwn1;
      end
      StOwn0:  if (!bus.wbm0_cyc_i) state_d = bus.wbm1_cyc_i ? StOwn1 : StIdle;
      StOwn1:  if (!bus.wbm1_cyc_i) state_d = bus.wbm0_cyc_i ? StOwn0 : StIdle;
      default: state_d = StIdle;
    endcase
    last_d  = last_q;
    grant_d = 2'b00;
    if (state_d == StOwn0) begin
      last_d  = 1'b0;
      grant_d = 2'b01;
    end else if (state_d == StOwn1) begin
      last_d  = 1'b1;
      grant_d = 2'b10;
    end
  end

  // Arbiter state, round-robin pointer and registered grant.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
      grant_q <= 2'b00;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
    end
  end

`ifdef WB_SRAM_ARB_WATCHDOG_EN
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] wd_cnt_q, wd_cnt_d;
  logic        aborted_q, aborted_d;
  logic        wd_err_q, wd_err_d;
  logic        own_cyc, own_stb_vis, slave_resp, wd_hit;

  // Count clocks of an unanswered strobe; on expiry cut the slave off until cyc drops.
  always_comb begin
    own_cyc     = (state_q == StOwn1) ? bus.wbm1_cyc_i : bus.wbm0_cyc_i;
    own_stb_vis = (state_q != StIdle) && !aborted_q &&
                  ((state_q == StOwn1) ? bus.wbm1_stb_i : bus.wbm0_stb_i);
    slave_resp  = bus.wbs_ack_i || bus.wbs_err_i || bus.wbs_rty_i;
    wd_hit      = own_stb_vis && own_cyc && !slave_resp && (wd_cnt_q == TimeoutLast);
    wd_cnt_d    = wd_cnt_q;
    if (state_d != state_q || slave_resp) wd_cnt_d = 16'd0;
    else if (own_stb_vis)                 wd_cnt_d = wd_cnt_q + 16'd1;
    aborted_d = (aborted_q || wd_hit) && (state_d == state_q);
    wd_err_d  = wd_hit;
  end

  // Watchdog registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wd_cnt_q  <= 16'd0;
      aborted_q <= 1'b0;
      wd_err_q  <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      aborted_q <= aborted_d;
      wd_err_q  <= wd_err_d;
    end
  end

  assign aborted = aborted_q;
  assign wd_err  = wd_err_q;
`else
  assign aborted = 1'b0;
  assign wd_err  = 1'b0;
`endif

  // Route the owner's request to the slave and the slave's response back to the owner.
  always_comb begin
    bus.wbs_cyc_o  = 1'b0;
    bus.wbs_stb_o  = 1'b0;
    bus.wbs_we_o   = 1'b0;
    adr_mux        = '0;
    bus.wbs_dat_o  = 8'h00;
    bus.wbm0_ack_o = 1'b0;
    bus.wbm0_err_o = 1'b0;
    bus.wbm0_rty_o = 1'b0;
    bus.wbm1_ack_o = 1'b0;
    bus.wbm1_err_o = 1'b0;
    bus.wbm1_rty_o = 1'b0;
    bus.wbm0_dat_o = bus.wbs_dat_i;
    bus.wbm1_dat_o = bus.wbs_dat_i;
    if (!rst_i) begin
      case (state_q)
        StOwn0: begin
          bus.wbs_cyc_o  = bus.wbm0_cyc_i && !aborted;
          bus.wbs_stb_o  = bus.wbm0_stb_i && !aborted;
          bus.wbs_we_o   = bus.wbm0_we_i;
          adr_mux        = bus.wbm0_adr_i;
          bus.wbs_dat_o  = bus.wbm0_dat_i;
          bus.wbm0_ack_o = bus.wbs_ack_i && !aborted;
          bus.wbm0_err_o = aborted ? wd_err : bus.wbs_err_i;
          bus.wbm0_rty_o = bus.wbs_rty_i && !aborted;
        end
        StOwn1: begin
          bus.wbs_cyc_o  = bus.wbm1_cyc_i && !aborted;
          bus.wbs_stb_o  = bus.wbm1_stb_i && !aborted;
          bus.wbs_we_o   = bus.wbm1_we_i;
          adr_mux        = bus.wbm1_adr_i;
          bus.wbs_dat_o  = bus.wbm1_dat_i;
          bus.wbm1_ack_o = bus.wbs_ack_i && !aborted;
          bus.wbm1_err_o = aborted ? wd_err : bus.wbs_err_i;
          bus.wbm1_rty_o = bus.wbs_rty_i && !aborted;
        end
        default: ;
      endcase
    end
  end

  assign bus.wbs_adr_o = adr_mux;
  assign grant_o       = grant_q;

endmodule

// File: tb/tb_wb_sram_arbiter.sv
// Self-checking bench for wb_sram_arbiter: directed scenarios plus a randomized run
// checked against an ownership model. Watchdog scenario built with WB_SRAM_ARB_WATCHDOG_EN.
module tb_wb_sram_arbiter;
  localparam int unsigned AW = 23;
  localparam int unsigned TO = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] grant;
  logic       auto_ack, man_ack;
  int         checks = 0;
  int         passes = 0;
  int         m_owner;   // 0 none, 1 m0, 2 m1
  bit         m_last;    // 1: m1 owned most recently

  wb_sram_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

  wb_sram_arbiter #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus    (bus.slave),
    .grant_o(grant)
  );

  always #5 clk = ~clk;

  // Slave responder: either acks every visible strobe or follows man_ack.
  always_comb bus.wbs_ack_i = auto_ack ? bus.wbs_stb_o : man_ack;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wbm0_cyc_i = 1'b0; bus.wbm0_stb_i = 1'b0; bus.wbm0_we_i = 1'b0;
    bus.wbm0_adr_i = '0;   bus.wbm0_dat_i = 8'h00;
    bus.wbm1_cyc_i = 1'b0; bus.wbm1_stb_i = 1'b0; bus.wbm1_we_i = 1'b0;
    bus.wbm1_adr_i = '0;   bus.wbm1_dat_i = 8'h00;
    bus.wbs_err_i  = 1'b0; bus.wbs_rty_i  = 1'b0; bus.wbs_dat_i = 8'h00;
    man_ack = 1'b0;
    auto_ack = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic model_step(input bit c0, input bit c1);
    int nxt;
    nxt = m_owner;
    if (m_owner == 0) begin
      if (c0 && c1) nxt = m_last ? 1 : 2;
      else if (c0)  nxt = 1;
      else if (c1)  nxt = 2;
    end else if (m_owner == 1 && !c0) begin
      nxt = c1 ? 2 : 0;
    end else if (m_owner == 2 && !c1) begin
      nxt = c0 ? 1 : 0;
    end
    if (nxt != 0) m_last = (nxt == 2);
    m_owner = nxt;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    bus.wbm0_cyc_i = 1'b1; bus.wbm0_stb_i = 1'b1; bus.wbm1_cyc_i = 1'b1;
    bus.wbm0_adr_i = 23'h7; bus.wbm0_dat_i = 8'h3C;
    man_ack = 1'b1; bus.wbs_err_i = 1'b1; bus.wbs_rty_i = 1'b1;
    tick();
    tick();
    checks++;
    if (grant !== 2'b00) $display("FAIL reset_grant: got %b want 00", grant);
    else passes++;
    checks++;
    if ({bus.wbs_cyc_o, bus.wbs_stb_o, bus.wbs_we_o} !== 3'b000)
      $display("FAIL reset_wbs_ctl: got %b want 000",
               {bus.wbs_cyc_o, bus.wbs_stb_o, bus.wbs_we_o});
    else passes++;
    checks++;
    if (bus.wbs_adr_o !== 23'h0) $display("FAIL reset_adr: got %h want 0", bus.wbs_adr_o);
    else passes++;
    checks++;
    if (bus.wbs_dat_o !== 8'h00) $display("FAIL reset_dat: got %h want 00", bus.wbs_dat_o);
    else passes++;
    checks++;
    if ({bus.wbm0_ack_o, bus.wbm0_err_o, bus.wbm0_rty_o,
         bus.wbm1_ack_o, bus.wbm1_err_o, bus.wbm1_rty_o} !== 6'b0)
      $display("FAIL reset_resp: got %b want 000000",
               {bus.wbm0_ack_o, bus.wbm0_err_o, bus.wbm0_rty_o,
                bus.wbm1_ack_o, bus.wbm1_err_o, bus.wbm1_rty_o});
    else passes++;
    idle_inputs();
  endtask

  task automatic test_single_master();
    int acks0 = 0;
    do_reset();
    bus.wbm0_cyc_i = 1'b1; bus.wbm0_stb_i = 1'b1; bus.wbm0_we_i = 1'b1;
    bus.wbm0_adr_i = 23'h000010; bus.wbm0_dat_i = 8'hA5;
    #1;
    checks++;
    if (bus.wbs_cyc_o !== 1'b0) $display("FAIL single_req_cyc: got %b want 0", bus.wbs_cyc_o);
    else passes++;
    tick();
    checks++;
    if (grant !== 2'b01) $display("FAIL single_grant: got %b want 01", grant);
    else passes++;
    checks++;
    if ({bus.wbs_cyc_o, bus.wbs_stb_o, bus.wbs_we_o} !== 3'b111)
      $display("FAIL single_ctl: got %b want 111",
               {bus.wbs_cyc_o, bus.wbs_stb_o, bus.wbs_we_o});
    else passes++;
    checks++;
    if (bus.wbs_adr_o !== 23'h000010) $display("FAIL single_adr: got %h want 10", bus.wbs_adr_o);
    else passes++;
    checks++;
    if (bus.wbs_dat_o !== 8'hA5) $display("FAIL single_dat: got %h want a5", bus.wbs_dat_o);
    else passes++;
    for (int k = 0; k < 6; k++) begin
      man_ack = (k == 3);
      bus.wbs_dat_i = (k == 3) ? 8'h5A : 8'h00;
      if (k >= 4) begin
        bus.wbm0_cyc_i = 1'b0; bus.wbm0_stb_i = 1'b0; bus.wbm0_we_i = 1'b0;
      end
      #1;
      if (bus.wbm0_ack_o === 1'b1) acks0++;
      checks++;
      if (bus.wbm1_ack_o !== 1'b0) $display("FAIL single_ack1 k=%0d: got %b want 0", k,
                                            bus.wbm1_ack_o);
      else passes++;
      if (k == 3) begin
        checks++;
        if (bus.wbm0_dat_o !== 8'h5A)
          $display("FAIL single_rdat: got %h want 5a", bus.wbm0_dat_o);
        else passes++;
      end
      tick();
    end
    checks++;
    if (acks0 !== 1) $display("FAIL single_ack_pulses: got %0d want 1", acks0);
    else passes++;
    checks++;
    if (grant !== 2'b00) $display("FAIL single_release: got %b want 00", grant);
    else passes++;
    idle_inputs();
  endtask

  task automatic test_tie();
    do_reset();
    bus.wbm0_cyc_i = 1'b1; bus.wbm0_stb_i = 1'b1; bus.wbm0_adr_i = 23'h000010;
    bus.wbm1_cyc_i = 1'b1; bus.wbm1_stb_i = 1'b1; bus.wbm1_adr_i = 23'h000020;
    tick();
    checks++;
    if (grant !== 2'b01) $display("FAIL tie_first: got %b want 01", grant);
    else passes++;
    checks++;
    if (bus.wbs_adr_o !== 23'h000010) $display("FAIL tie_adr0: got %h want 10", bus.wbs_adr_o);
    else passes++;
    man_ack = 1'b1;
    #1;
    checks++;
    if ({bus.wbm0_ack_o, bus.wbm1_ack_o} !== 2'b10)
      $display("FAIL tie_ack: got %b want 10", {bus.wbm0_ack_o, bus.wbm1_ack_o});
    else passes++;
    tick();
    man_ack = 1'b0;
    bus.wbm0_cyc_i = 1'b0; bus.wbm0_stb_i = 1'b0;
    #1;
    checks++;
    if (grant !== 2'b01) $display("FAIL tie_hold: got %b want 01", grant);
    else passes++;
    tick();
    checks++;
    if (grant !== 2'b10) $display("FAIL tie_switch: got %b want 10", grant);
    else passes++;
    checks++;
    if ({bus.wbs_cyc_o, bus.wbs_adr_o} !== {1'b1, 23'h000020})
      $display("FAIL tie_m1_path: got %b/%h want 1/20", bus.wbs_cyc_o, bus.wbs_adr_o);
    else passes++;
    idle_inputs();
  endtask

  task automatic test_alternation();
    int done0 = 0, done1 = 0, low0 = 0, low1 = 0;
    logic [1:0] prev_g = 2'b00;
    logic [1:0] runs[$];
    logic [1:0] want;
    do_reset();
    auto_ack = 1'b1;
    for (int k = 0; k < 80 && !(done0 == 4 && done1 == 4); k++) begin
      bus.wbm0_cyc_i = (done0 < 4) && (low0 == 0); bus.wbm0_stb_i = bus.wbm0_cyc_i;
      bus.wbm1_cyc_i = (done1 < 4) && (low1 == 0); bus.wbm1_stb_i = bus.wbm1_cyc_i;
      #1;
      if (grant != 2'b00 && grant != prev_g) runs.push_back(grant);
      prev_g = grant;
      if (low0 > 0) low0--;
      if (low1 > 0) low1--;
      if (bus.wbm0_ack_o === 1'b1) begin done0++; low0 = 1; end
      if (bus.wbm1_ack_o === 1'b1) begin done1++; low1 = 1; end
      tick();
    end
    checks++;
    if (done0 != 4 || done1 != 4)
      $display("FAIL alt_done: got %0d/%0d want 4/4", done0, done1);
    else passes++;
    checks++;
    if (runs.size() != 8) $display("FAIL alt_runs: got %0d want 8", runs.size());
    else passes++;
    foreach (runs[i]) begin
      want = (i % 2 == 0) ? 2'b01 : 2'b10;
      checks++;
      if (runs[i] !== want) $display("FAIL alt_grant[%0d]: got %b want %b", i, runs[i], want);
      else passes++;
    end
    idle_inputs();
  endtask

  task automatic test_hold();
    int n1 = 0, at_switch = -1;
    bit switched = 1'b0;
    do_reset();
    auto_ack = 1'b1;
    bus.wbm1_cyc_i = 1'b1; bus.wbm1_stb_i = 1'b1;
    tick();
    bus.wbm0_cyc_i = 1'b1; bus.wbm0_stb_i = 1'b1;
    for (int k = 0; k < 20 && !switched; k++) begin
      if (n1 >= 3) begin bus.wbm1_cyc_i = 1'b0; bus.wbm1_stb_i = 1'b0; end
      #1;
      if (grant === 2'b01) begin
        switched = 1'b1;
        at_switch = n1;
      end else begin
        if (bus.wbm1_ack_o === 1'b1) n1++;
        checks++;
        if (bus.wbm0_ack_o !== 1'b0) $display("FAIL hold_ack0 k=%0d: got %b want 0", k,
                                              bus.wbm0_ack_o);
        else passes++;
        tick();
      end
    end
    checks++;
    if (!switched || at_switch != 3)
      $display("FAIL hold_beats: got %0d beats (switched=%0b) want 3", at_switch, switched);
    else passes++;
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.wbm1_cyc_i = 1'b1; bus.wbm1_stb_i = 1'b1; bus.wbm1_adr_i = 23'h000055;
    tick();
    checks++;
    if (grant !== 2'b10) $display("FAIL rstmid_own1: got %b want 10", grant);
    else passes++;
    rst = 1'b1;
    tick();
    man_ack = 1'b1;
    #1;
    checks++;
    if (bus.wbs_cyc_o !== 1'b0) $display("FAIL rstmid_cyc: got %b want 0", bus.wbs_cyc_o);
    else passes++;
    checks++;
    if (grant !== 2'b00) $display("FAIL rstmid_grant: got %b want 00", grant);
    else passes++;
    checks++;
    if ({bus.wbm0_ack_o, bus.wbm1_ack_o} !== 2'b00)
      $display("FAIL rstmid_ack: got %b want 00", {bus.wbm0_ack_o, bus.wbm1_ack_o});
    else passes++;
    idle_inputs();
    rst = 1'b0;
    tick();
  endtask

`ifdef WB_SRAM_ARB_WATCHDOG_EN
  task automatic test_watchdog();
    int rise = -1, err_at = -1, errs = 0;
    do_reset();
    bus.wbm0_cyc_i = 1'b1; bus.wbm0_stb_i = 1'b1;
    for (int k = 0; k < 30; k++) begin
      if (rise < 0 && bus.wbs_stb_o === 1'b1) rise = k;
      if (err_at >= 0 && k > err_at) begin
        checks++;
        if (bus.wbs_cyc_o !== 1'b0) $display("FAIL wd_cyc_cut k=%0d: got %b want 0", k,
                                             bus.wbs_cyc_o);
        else passes++;
      end
      if (bus.wbm0_err_o === 1'b1) begin
        errs++;
        if (err_at < 0) err_at = k;
      end
      tick();
    end
    checks++;
    if (errs != 1) $display("FAIL wd_err_pulses: got %0d want 1", errs);
    else passes++;
    checks++;
    if (rise < 0 || err_at - rise != 8)
      $display("FAIL wd_err_delay: got %0d want 8", err_at - rise);
    else passes++;
    bus.wbm0_cyc_i = 1'b0; bus.wbm0_stb_i = 1'b0;
    bus.wbm1_cyc_i = 1'b1; bus.wbm1_stb_i = 1'b1;
    auto_ack = 1'b1;
    tick();
    checks++;
    if ({grant, bus.wbs_cyc_o, bus.wbm1_ack_o} !== 4'b1011)
      $display("FAIL wd_next_m1: got %b want 1011", {grant, bus.wbs_cyc_o, bus.wbm1_ack_o});
    else passes++;
    idle_inputs();
  endtask
`endif

  task automatic test_random();
    int bts[2], idl[2];
    int wt = 0, prev_owner;
    bit c[2], s[2];
    logic ack, resp;
    logic [33:0] exp_bus;
    logic [5:0]  exp_resp;
    logic [1:0]  exp_grant;
    do_reset();
    m_owner = 0;
    m_last  = 1'b1;
    bts = '{0, 0};
    idl = '{0, 0};
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (bts[i] == 0 && idl[i] == 0) bts[i] = $urandom_range(1, 3);
        c[i] = (bts[i] > 0);
        s[i] = c[i] && ($urandom_range(0, 3) != 0);
      end
      bus.wbm0_cyc_i = c[0]; bus.wbm0_stb_i = s[0]; bus.wbm0_we_i = 1'($urandom);
      bus.wbm0_adr_i = 23'($urandom); bus.wbm0_dat_i = 8'($urandom);
      bus.wbm1_cyc_i = c[1]; bus.wbm1_stb_i = s[1]; bus.wbm1_we_i = 1'($urandom);
      bus.wbm1_adr_i = 23'($urandom); bus.wbm1_dat_i = 8'($urandom);
      exp_bus = '0;
      if (m_owner == 1)
        exp_bus = {c[0], s[0], bus.wbm0_we_i, bus.wbm0_adr_i, bus.wbm0_dat_i};
      else if (m_owner == 2)
        exp_bus = {c[1], s[1], bus.wbm1_we_i, bus.wbm1_adr_i, bus.wbm1_dat_i};
      ack = exp_bus[32] && ($urandom_range(0, 1) == 1 || wt >= 3);
      man_ack = ack;
      bus.wbs_err_i = !ack && ($urandom_range(0, 7) == 0);
      bus.wbs_rty_i = !ack && ($urandom_range(0, 7) == 0);
      bus.wbs_dat_i = 8'($urandom);
      exp_resp = '0;
      if (m_owner == 1) exp_resp[5:3] = {ack, bus.wbs_err_i, bus.wbs_rty_i};
      if (m_owner == 2) exp_resp[2:0] = {ack, bus.wbs_err_i, bus.wbs_rty_i};
      exp_grant = (m_owner == 1) ? 2'b01 : (m_owner == 2) ? 2'b10 : 2'b00;
      #1;
      checks++;
      if (grant !== exp_grant) $display("FAIL rnd_grant n=%0d: got %b want %b", n, grant,
                                        exp_grant);
      else passes++;
      checks++;
      if ({bus.wbs_cyc_o, bus.wbs_stb_o, bus.wbs_we_o, bus.wbs_adr_o, bus.wbs_dat_o}
          !== exp_bus)
        $display("FAIL rnd_slave n=%0d: got %h want %h", n,
                 {bus.wbs_cyc_o, bus.wbs_stb_o, bus.wbs_we_o, bus.wbs_adr_o, bus.wbs_dat_o},
                 exp_bus);
      else passes++;
      checks++;
      if ({bus.wbm0_ack_o, bus.wbm0_err_o, bus.wbm0_rty_o,
           bus.wbm1_ack_o, bus.wbm1_err_o, bus.wbm1_rty_o} !== exp_resp)
        $display("FAIL rnd_resp n=%0d: got %b want %b", n,
                 {bus.wbm0_ack_o, bus.wbm0_err_o, bus.wbm0_rty_o,
                  bus.wbm1_ack_o, bus.wbm1_err_o, bus.wbm1_rty_o}, exp_resp);
      else passes++;
      if (m_owner != 0) begin
        checks++;
        if (((m_owner == 1) ? bus.wbm0_dat_o : bus.wbm1_dat_o) !== bus.wbs_dat_i)
          $display("FAIL rnd_rdat n=%0d: got %h want %h", n,
                   (m_owner == 1) ? bus.wbm0_dat_o : bus.wbm1_dat_o, bus.wbs_dat_i);
        else passes++;
      end
      resp = ack || bus.wbs_err_i || bus.wbs_rty_i;
      wt = resp ? 0 : wt + int'(exp_bus[32]);
      for (int i = 0; i < 2; i++) begin
        if (m_owner == i + 1 && ack) begin
          bts[i]--;
          if (bts[i] == 0) idl[i] = $urandom_range(1, 3);
        end else if (bts[i] == 0 && idl[i] > 0) begin
          idl[i]--;
        end
      end
      tick();
      prev_owner = m_owner;
      model_step(c[0], c[1]);
      if (m_owner != prev_owner) wt = 0;
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_single_master();
    test_tie();
    test_alternation();
    test_hold();
    test_reset_mid();
`ifdef WB_SRAM_ARB_WATCHDOG_EN
    test_watchdog();
`endif
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL sim_timeout: got no finish want finish before time limit");
    $fatal(1, "simulation time limit reached");
  end

endmodule
